// File: rtl/bs_word_adapter.sv
// -----------------------------------------------------------------------------
// bs_word_adapter
//   Parallel <-> bit-serial adapter for the bit-serial multiplier datapath.
//   TX: accepts operand pairs on a valid/ready handshake and streams them
//       LSB-first onto s_x/s_y, framed by s_first/s_last. Back-to-back
//       frames are gapless because a new pair is accepted during the last bit.
//   RX: s_first is delayed by P_LAT cycles to mark product bit 0 on s_p; W
//       serial bits are collected into a parallel word presented on
//       out_data/out_valid.
//
// Parameters
//   W      word length and serial frame length (W >= 2)
//   P_LAT  cycles from the s_first cycle to the cycle carrying product bit 0
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       operand pair handshake
//   in_x, in_y [W-1:0]      parallel operands, sampled only on acceptance
//   s_x, s_y                serial operand bits to the multiplier
//   s_first, s_last         frame markers on bit 0 / bit W-1
//   s_p                     serial product bit from the multiplier
//   out_valid/out_ready     product word handshake
//   out_data [W-1:0]        assembled product word
//   ovf                     sticky: a product overwrote an unread one
// -----------------------------------------------------------------------------
module bs_word_adapter #(
    parameter int W     = 16,
    parameter int P_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         s_x,
    output logic         s_y,
    output logic         s_first,
    output logic         s_last,
    input  logic         s_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         ovf
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [CW-1:0] r_cnt;      // index of the bit currently on s_x/s_y
    logic [W-1:0]  r_sh_x;     // bits still to be sent, LSB next
    logic [W-1:0]  r_sh_y;
    logic          r_s_x;
    logic          r_s_y;
    logic          r_s_first;
    logic          r_s_last;

    logic w_in_ready;
    logic w_accept;

    // Ready while idle, and during the last bit of a frame so the next frame
    // follows without a gap.
    assign w_in_ready = (r_state == ST_IDLE) || (r_cnt == LAST);
    assign w_accept   = in_valid && w_in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_s_x     <= 1'b0;
            r_s_y     <= 1'b0;
            r_s_first <= 1'b0;
            r_s_last  <= 1'b0;
        end else if (w_accept) begin
            // Bit 0 goes straight to the output register; the rest waits.
            r_state   <= ST_SHIFT;
            r_cnt     <= '0;
            r_s_x     <= in_x[0];
            r_s_y     <= in_y[0];
            r_sh_x    <= in_x >> 1;
            r_sh_y    <= in_y >> 1;
            r_s_first <= 1'b1;
            r_s_last  <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            if (r_cnt == LAST) begin
                r_state   <= ST_IDLE;
                r_s_x     <= 1'b0;
                r_s_y     <= 1'b0;
                r_s_first <= 1'b0;
                r_s_last  <= 1'b0;
            end else begin
                r_cnt     <= r_cnt + CW'(1);
                r_s_x     <= r_sh_x[0];
                r_s_y     <= r_sh_y[0];
                r_sh_x    <= r_sh_x >> 1;
                r_sh_y    <= r_sh_y >> 1;
                r_s_first <= 1'b0;
                r_s_last  <= (r_cnt == LAST - CW'(1));
            end
        end
    end

    assign in_ready = w_in_ready;
    assign s_x      = r_s_x;
    assign s_y      = r_s_y;
    assign s_first  = r_s_first;
    assign s_last   = r_s_last;

    // ------------------------------------------------------------------
    // Product-start marker: s_first delayed by P_LAT cycles
    // ------------------------------------------------------------------
    logic w_marker;

    generate
        if (P_LAT == 0) begin : g_no_delay
            assign w_marker = r_s_first;
        end else begin : g_delay
            logic [P_LAT-1:0] r_first_dly;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_first_dly <= '0;
                end else begin
                    r_first_dly <= (r_first_dly << 1) | P_LAT'(r_s_first);
                end
            end

            assign w_marker = r_first_dly[P_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // RX capture
    // ------------------------------------------------------------------
    logic          r_cap_active;
    logic [CW-1:0] r_cap_cnt;   // product bits captured so far
    logic [W-1:0]  r_prod;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic          r_ovf;

    logic         w_cap_bit;
    logic         w_cap_done;
    logic [W-1:0] w_prod_next;

    // Right shift with s_p entering at the top: after W shifts the first
    // captured bit sits at bit 0.
    assign w_prod_next = {s_p, r_prod[W-1:1]};
    assign w_cap_bit   = w_marker || r_cap_active;
    assign w_cap_done  = r_cap_active && (r_cap_cnt == LAST);

    // NOTE: the product shift register is reset along with the control state
    // so that no stale bits from an interrupted frame can ever reach out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_active <= 1'b0;
            r_cap_cnt    <= '0;
            r_prod       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_cap_bit) begin
                r_prod <= w_prod_next;
            end

            if (w_marker) begin
                r_cap_active <= 1'b1;
                r_cap_cnt    <= CW'(1);
            end else if (r_cap_active) begin
                r_cap_cnt <= r_cap_cnt + CW'(1);
                if (w_cap_done) begin
                    r_cap_active <= 1'b0;
                end
            end

            // A completion wins over a pop in the same cycle; completing onto
            // an unread word overwrites it and flags the loss.
            if (w_cap_done) begin
                r_out_data  <= w_prod_next;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_ovf <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bs_word_adapter.sv
// -----------------------------------------------------------------------------
// tb_bs_word_adapter
//   Scoreboard bench for bs_word_adapter (W=16, P_LAT=1). A behavioural
//   bit-serial multiplier rebuilds the operands from s_x/s_y, drives the
//   product bits on s_p one cycle behind, and checks framing. Accepted pairs
//   push the expected low product word and its due cycle; a monitor pops on
//   completion and tracks out_valid/out_data/ovf from the handshake rules.
// -----------------------------------------------------------------------------
module tb_bs_word_adapter;

    localparam int W     = 16;
    localparam int P_LAT = 1;
    localparam int LAT   = W + P_LAT + 1;  // acceptance cycle -> out_valid cycle

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_x      = '0;
    logic [W-1:0] in_y      = '0;
    logic         s_x;
    logic         s_y;
    logic         s_first;
    logic         s_last;
    logic         s_p       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         ovf;

    bs_word_adapter #(.W(W), .P_LAT(P_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .s_x       (s_x),
        .s_y       (s_y),
        .s_first   (s_first),
        .s_last    (s_last),
        .s_p       (s_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           acc;
    } tx_t;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } sb_t;

    tx_t tx_q[$];
    sb_t sb_q[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int last_due   = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] f;
        f = (2*W)'(a) * (2*W)'(b);
        return f[W-1:0];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a pair and hold it until accepted; record the expectations.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        bit  done = 1'b0;
        tx_t t;
        sb_t s;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                t.x = x; t.y = y; t.acc = cyc;
                s.data = mul_lo(x, y); s.due = cyc + LAT;
                tx_q.push_back(t);
                sb_q.push_back(s);
                last_due = s.due;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_x     = W'($urandom);  // must be ignored after acceptance
        in_y     = W'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (tx_q.size() != 0 || sb_q.size() != 0); i++) wait_cyc(1);
        check("drain", 32'(tx_q.size() + sb_q.size()), 32'd0);
        wait_cyc(2);
    endtask

    // Behavioural bit-serial multiplier plus TX framing checks.
    initial begin
        bit             in_frame = 1'b0;
        int             j = 0;
        logic [W-1:0]   xa = '0;
        logic [W-1:0]   ya = '0;
        logic [2*W-1:0] pr;
        logic           pbit;
        tx_t            cur;
        cur.x = '0; cur.y = '0; cur.acc = 0;
        forever begin
            @(negedge clk);
            pbit = 1'($urandom);  // don't-care outside a frame
            if (!rst_n) begin
                in_frame = 1'b0;
            end else begin
                if (s_first) begin
                    if (in_frame) check("frame_overlap", 32'(j), 32'(W));
                    if (tx_q.size() == 0) begin
                        check("unexpected_first", 32'd1, 32'd0);
                        in_frame = 1'b0;
                    end else begin
                        cur = tx_q.pop_front();
                        check("first_timing", 32'(cyc), 32'(cur.acc + 1));
                        in_frame = 1'b1;
                        j  = 0;
                        xa = '0;
                        ya = '0;
                    end
                end
                if (in_frame) begin
                    xa = xa | (W'(s_x) << j);
                    ya = ya | (W'(s_y) << j);
                    check("s_last", 32'(s_last), 32'(j == W - 1));
                    pr   = (2*W)'(xa) * (2*W)'(ya);
                    pbit = 1'(pr >> j);
                    if (j == W - 1) begin
                        check("frame_x", 32'(xa), 32'(cur.x));
                        check("frame_y", 32'(ya), 32'(cur.y));
                        in_frame = 1'b0;
                    end
                    j++;
                end else begin
                    check("idle_lines", {29'd0, s_x, s_y, s_last}, 32'd0);
                end
            end
            @(posedge clk);
            #1 s_p = pbit;
        end
    end

    // Output monitor / scoreboard.
    initial begin
        bit           exp_valid  = 1'b0;
        bit           exp_ovf    = 1'b0;
        bit           prev_ready = 1'b1;
        logic [W-1:0] exp_data   = '0;
        sb_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_valid = 1'b0;
                exp_ovf   = 1'b0;
            end else begin
                if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                    check("late_completion", 32'(cyc), 32'(sb_q[0].due));
                    e = sb_q.pop_front();
                end
                if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                    e = sb_q.pop_front();
                    if (exp_valid && !prev_ready) exp_ovf = 1'b1;
                    exp_valid = 1'b1;
                    exp_data  = e.data;
                end else if (prev_ready) begin
                    exp_valid = 1'b0;
                end
                check("out_valid", 32'(out_valid), 32'(exp_valid));
                if (exp_valid) check("out_data", 32'(out_data), 32'(exp_data));
                check("ovf", 32'(ovf), 32'(exp_ovf));
            end
            prev_ready = out_ready;
        end
    end

    // Random consumer backpressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;

        // Reset state
        wait_cyc(2);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_s_first",   32'(s_first),   32'd0);
        check("rst_s_x",       32'(s_x),       32'd0);
        #3 rst_n = 1'b1;
        wait_cyc(2);

        // Single frame: 3 * 5
        send(16'h0003, 16'h0005);
        drain();

        // Back-to-back frames
        send(16'hFFFF, 16'h0001);
        send(16'h00FF, 16'h0100);
        send(16'h1234, 16'h0000);
        drain();

        // Pop on the same cycle as the next completion: no overflow
        out_ready = 1'b0;
        send(16'h0102, 16'h0304);
        send(16'h0BAD, 16'h0007);
        for (int i = 0; i < 100 && cyc < last_due - 1; i++) wait_cyc(1);
        out_ready = 1'b1;
        wait_cyc(2);
        check("pop_complete_ovf", 32'(ovf), 32'd0);
        drain();

        // Backpressure across two completions: overwrite and sticky ovf
        out_ready = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        send(16'h0011, 16'h0022);
        send(a, b);
        drain();
        check("bp_ovf",   32'(ovf),       32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data",  32'(out_data),  32'(mul_lo(a, b)));
        out_ready = 1'b1;
        wait_cyc(3);
        check("bp_ovf_sticky", 32'(ovf),       32'd1);
        check("bp_popped",     32'(out_valid), 32'd0);

        // Gap between frames: back to IDLE, then a clean restart
        send(W'($urandom), W'($urandom));
        wait_cyc(W + 2);
        check("gap_in_ready", 32'(in_ready), 32'd1);
        check("gap_lines", {28'd0, s_x, s_y, s_first, s_last}, 32'd0);
        wait_cyc(5);
        send(16'hFFFF, 16'hFFFF);
        drain();

        // Random operands, gaps and backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) wait_cyc(gap);
            case ($urandom_range(0, 5))
                0:       send(16'hFFFF, W'($urandom));
                1:       send(W'($urandom), 16'h0000);
                default: send(W'($urandom), W'($urandom));
            endcase
        end
        drain();
        rand_ready = 1'b0;
        wait_cyc(1);
        out_ready = 1'b1;
        wait_cyc(3);

        // Reset in the middle of a frame with a word held
        out_ready = 1'b0;
        send(W'($urandom), W'($urandom));
        send(W'($urandom), W'($urandom));
        wait_cyc(5);
        #2;
        rst_n = 1'b0;
        tx_q.delete();
        sb_q.delete();
        #1;
        check("midrst_s_first",   32'(s_first),   32'd0);
        check("midrst_s_last",    32'(s_last),    32'd0);
        check("midrst_s_x",       32'(s_x),       32'd0);
        check("midrst_s_y",       32'(s_y),       32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_ovf",       32'(ovf),       32'd0);
        wait_cyc(3);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        wait_cyc(40);
        check("post_rst_quiet", 32'(out_valid), 32'd0);
        send(16'h0003, 16'h0005);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
